// File: rtl/particle_stream_gen.sv
// Particle stimulus source: NUM_CH particles per beat on a ready/valid stream,
// framed with m_last every FRAME_LEN beats, in constant, LFSR or ramp data mode.
module particle_stream_gen #(
  parameter int          NUM_CH    = 2,
  parameter int          POS_W     = 18,
  parameter int          VEL_W     = 14,
  parameter int          FRAME_LEN = 501,
  parameter logic [31:0] SEED      = 32'hACE1_0001,
  localparam int         PW        = 2*POS_W + VEL_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [15:0]          num_frames,
  input  logic [NUM_CH*PW-1:0] init_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic [NUM_CH*PW-1:0] m_data,
  output logic [15:0]          frame_cnt,
  output logic                 done
);

  localparam int            BW        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0000_0000);
  endfunction

  // A seed that collapses to zero would lock the LFSR, so it is forced to 1.
  function automatic logic [31:0] seed_of(input int c);
    logic [31:0] s;
    s = SEED ^ (32'(c) * 32'h9E37_79B9);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

  function automatic logic [PW-1:0] build_ch(input logic [1:0]    md,
                                             input logic [BW-1:0] beat,
                                             input logic [15:0]   frm,
                                             input logic [31:0]   l,
                                             input int            c,
                                             input logic [PW-1:0] cst);
    case (md)
      2'd1:    return {l[POS_W-1:0], l[31 -: POS_W], l[VEL_W-1:0] ^ l[31 -: VEL_W]};
      2'd2:    return {POS_W'(beat) * POS_W'(NUM_CH) + POS_W'(c), POS_W'(frm), VEL_W'(c)};
      default: return cst;
    endcase
  endfunction

  state_t                r_state;
  logic                  r_valid;
  logic                  r_last;
  logic                  r_done;
  logic [NUM_CH*PW-1:0]  r_data;
  logic [BW-1:0]         r_beat_cnt;
  logic [15:0]           r_frame_cnt;
  logic [15:0]           r_num_frames;
  logic [1:0]            r_mode;
  logic [31:0]           r_lfsr [NUM_CH];

  logic                  w_accept;
  logic                  w_last_beat;
  logic                  w_finish;
  logic                  w_first;
  logic [BW-1:0]         w_beat_nxt;
  logic [BW-1:0]         w_src_beat;
  logic [15:0]           w_frame_nxt;
  logic [15:0]           w_src_frame;
  logic [1:0]            w_mode_sel;
  logic [31:0]           w_lfsr_nxt [NUM_CH];
  logic [31:0]           w_src_lfsr [NUM_CH];
  logic [NUM_CH*PW-1:0]  w_data;

  // r_valid is only ever high in ST_RUN, so an accept implies the running state.
  assign w_accept    = r_valid & m_ready;
  assign w_last_beat = (r_beat_cnt == LAST_BEAT);
  assign w_beat_nxt  = w_last_beat ? '0 : r_beat_cnt + BW'(1);
  assign w_frame_nxt = w_last_beat ? r_frame_cnt + 16'd1 : r_frame_cnt;
  assign w_finish    = w_last_beat && (r_num_frames != 16'd0) && (w_frame_nxt == r_num_frames);

  // The beat being loaded comes from the post-accept counters, or the current ones on resume.
  assign w_src_beat  = w_accept ? w_beat_nxt : r_beat_cnt;
  assign w_src_frame = w_accept ? w_frame_nxt : r_frame_cnt;
  assign w_first     = (w_src_beat == '0);
  assign w_mode_sel  = w_first ? mode : r_mode;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lfsr
    assign w_lfsr_nxt[g] = lfsr_step(r_lfsr[g]);
    assign w_src_lfsr[g] = w_accept ? w_lfsr_nxt[g] : r_lfsr[g];
  end

  // Assemble the next beat's particles for every channel.
  always_comb begin
    w_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_data[c*PW +: PW] = build_ch(w_mode_sel, w_src_beat, w_src_frame, w_src_lfsr[c], c,
                                    init_data[c*PW +: PW]);
    end
  end

  // Stream control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_valid      <= 1'b0;
      r_last       <= 1'b0;
      r_done       <= 1'b0;
      r_data       <= '0;
      r_beat_cnt   <= '0;
      r_frame_cnt  <= 16'd0;
      r_num_frames <= 16'd0;
      r_mode       <= 2'd0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_lfsr[c] <= seed_of(c);
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            r_state <= ST_RUN;
            r_valid <= 1'b1;
            r_last  <= (w_src_beat == LAST_BEAT);
            r_data  <= w_data;
            if (w_first) begin
              r_mode       <= mode;
              r_num_frames <= num_frames;
            end
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            r_beat_cnt  <= w_beat_nxt;
            r_frame_cnt <= w_frame_nxt;
            for (int c = 0; c < NUM_CH; c++) begin
              r_lfsr[c] <= w_lfsr_nxt[c];
            end
            if (w_finish) begin
              r_state <= ST_DONE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
            end else if (en) begin
              r_last <= (w_src_beat == LAST_BEAT);
              r_data <= w_data;
              if (w_first) begin
                r_mode       <= mode;
                r_num_frames <= num_frames;
              end
            end else begin
              r_state <= ST_IDLE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          r_valid <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

  assign m_valid   = r_valid;
  assign m_last    = r_last;
  assign m_data    = r_data;
  assign frame_cnt = r_frame_cnt;
  assign done      = r_done;

endmodule

// File: tb/tb_particle_stream_gen.sv
// Bench for particle_stream_gen: table-driven ramp frames plus hand-written
// stall, pause, reset, LFSR and constant-mode sequences checked through a scoreboard.
module tb_particle_stream_gen;

  localparam int DW = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [1:0]    mode;
  logic [15:0]   num_frames;
  logic [DW-1:0] init_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic [DW-1:0] m_data;
  logic [15:0]   frame_cnt;
  logic          done;

  particle_stream_gen #(
    .NUM_CH(2), .POS_W(18), .VEL_W(14), .FRAME_LEN(4), .SEED(32'h0000_0001)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .num_frames(num_frames),
    .init_data(init_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .m_data(m_data), .frame_cnt(frame_cnt), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [15:0]   fc;
  } exp_t;

  typedef struct {
    logic [17:0] x0;
    logic [17:0] x1;
    logic [17:0] y;
    logic        last;
    logic [15:0] fc;
  } vec_t;

  exp_t sbq[$];
  vec_t ramp_tab [8];
  int   n_vec = 0;
  int   n_err = 0;
  int   acc_cnt = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  function automatic exp_t ramp_exp(input vec_t v);
    exp_t e;
    e.data = {v.x1, v.y, 14'd1, v.x0, v.y, 14'd0};
    e.last = v.last;
    e.fc   = v.fc;
    return e;
  endfunction

  function automatic logic [49:0] lfsr_map(input logic [31:0] l);
    return {l[17:0], l[31:14], l[13:0] ^ l[31:18]};
  endfunction

  function automatic logic [31:0] lfsr_model(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
  endfunction

  task automatic push_ramp(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) sbq.push_back(ramp_exp(ramp_tab[i]));
  endtask

  // One clock: score any beat accepted at the coming edge, then step to just after it.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!rst && m_valid && m_ready) begin
      acc_cnt++;
      if (sbq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_beat: got data %h, required no beat", m_data);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("beat%0d_data", acc_cnt), m_data, e.data);
        chk($sformatf("beat%0d_last", acc_cnt), DW'(m_last), DW'(e.last));
        chk($sformatf("beat%0d_frame_cnt", acc_cnt), DW'(frame_cnt), DW'(e.fc));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int target, input int budget);
    int k = 0;
    while (acc_cnt < target && k < budget) begin
      tick();
      k++;
    end
    if (acc_cnt < target) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_accepts: got %0d beats, required %0d", acc_cnt, target);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    m_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    acc_cnt = 0;
  endtask

  task automatic chk_done(input string nm, input logic [15:0] fc);
    chk({nm, "_done"}, DW'(done), DW'(1'b1));
    chk({nm, "_valid"}, DW'(m_valid), DW'(1'b0));
    chk({nm, "_frame_cnt"}, DW'(frame_cnt), DW'(fc));
    chk({nm, "_sb_empty"}, DW'(sbq.size()), DW'(0));
  endtask

  initial begin
    exp_t        e;
    logic [31:0] l0;
    logic [31:0] l1;

    ramp_tab[0] = '{18'd0, 18'd1, 18'd0, 1'b0, 16'd0};
    ramp_tab[1] = '{18'd2, 18'd3, 18'd0, 1'b0, 16'd0};
    ramp_tab[2] = '{18'd4, 18'd5, 18'd0, 1'b0, 16'd0};
    ramp_tab[3] = '{18'd6, 18'd7, 18'd0, 1'b1, 16'd0};
    ramp_tab[4] = '{18'd0, 18'd1, 18'd1, 1'b0, 16'd1};
    ramp_tab[5] = '{18'd2, 18'd3, 18'd1, 1'b0, 16'd1};
    ramp_tab[6] = '{18'd4, 18'd5, 18'd1, 1'b0, 16'd1};
    ramp_tab[7] = '{18'd6, 18'd7, 18'd1, 1'b1, 16'd1};

    mode = 2'd0;
    num_frames = 16'd0;
    init_data = '0;
    do_reset();
    chk("rst_valid", DW'(m_valid), DW'(1'b0));
    chk("rst_last", DW'(m_last), DW'(1'b0));
    chk("rst_data", m_data, '0);
    chk("rst_frame_cnt", DW'(frame_cnt), DW'(0));
    chk("rst_done", DW'(done), DW'(1'b0));

    // Two finite ramp frames at full rate.
    mode = 2'd2;
    num_frames = 16'd2;
    m_ready = 1'b1;
    push_ramp(0, 7);
    en = 1'b1;
    wait_acc(8, 40);
    chk_done("ramp2", 16'd2);
    repeat (3) tick();
    chk("ramp2_hold_valid", DW'(m_valid), DW'(1'b0));
    chk("ramp2_hold_done", DW'(done), DW'(1'b1));

    // Backpressure on beat 2 for three cycles.
    do_reset();
    mode = 2'd2;
    num_frames = 16'd2;
    m_ready = 1'b1;
    push_ramp(0, 7);
    en = 1'b1;
    wait_acc(2, 20);
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", DW'(m_valid), DW'(1'b1));
      chk("stall_data", m_data, ramp_exp(ramp_tab[2]).data);
      chk("stall_last", DW'(m_last), DW'(1'b0));
    end
    m_ready = 1'b1;
    wait_acc(8, 40);
    chk_done("stall", 16'd2);

    // Pause after two accepted beats, resume mid-frame.
    do_reset();
    mode = 2'd2;
    num_frames = 16'd1;
    m_ready = 1'b1;
    push_ramp(0, 3);
    en = 1'b1;
    wait_acc(1, 20);
    en = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("pause_valid", DW'(m_valid), DW'(1'b0));
      tick();
    end
    chk("pause_accepts", DW'(acc_cnt), DW'(2));
    en = 1'b1;
    wait_acc(4, 20);
    chk_done("pause", 16'd1);

    // Reset while frame 1 beat 3 is presented, then restart from scratch.
    do_reset();
    mode = 2'd2;
    num_frames = 16'd0;
    m_ready = 1'b1;
    push_ramp(0, 6);
    en = 1'b1;
    wait_acc(7, 40);
    chk("midrst_pre_last", DW'(m_last), DW'(1'b1));
    chk("midrst_pre_data", m_data, ramp_exp(ramp_tab[7]).data);
    rst = 1'b1;
    m_ready = 1'b0;
    en = 1'b0;
    tick();
    chk("midrst_valid", DW'(m_valid), DW'(1'b0));
    chk("midrst_last", DW'(m_last), DW'(1'b0));
    chk("midrst_data", m_data, '0);
    chk("midrst_frame_cnt", DW'(frame_cnt), DW'(0));
    chk("midrst_done", DW'(done), DW'(1'b0));
    rst = 1'b0;
    acc_cnt = 0;
    tick();
    num_frames = 16'd1;
    m_ready = 1'b1;
    push_ramp(0, 3);
    en = 1'b1;
    wait_acc(4, 20);
    chk_done("restart", 16'd1);

    // LFSR mode: seeds must be back to their reset values.
    do_reset();
    mode = 2'd1;
    num_frames = 16'd1;
    m_ready = 1'b1;
    l0 = 32'h0000_0001;
    l1 = 32'h9E37_79B8;
    for (int b = 0; b < 4; b++) begin
      e.data = {lfsr_map(l1), lfsr_map(l0)};
      e.last = (b == 3);
      e.fc   = 16'd0;
      sbq.push_back(e);
      l0 = lfsr_model(l0);
      l1 = lfsr_model(l1);
    end
    en = 1'b1;
    wait_acc(1, 20);
    chk("lfsr_beat1_ch0", DW'(m_data[49:0]), DW'({18'h00003, 18'h20080, 14'h0003 ^ 14'h2008}));
    wait_acc(4, 20);
    chk_done("lfsr", 16'd1);

    // Reserved mode replays init_data like constant mode.
    do_reset();
    mode = 2'd3;
    num_frames = 16'd1;
    init_data = 100'h5_A5A5_1234_5678_9ABC_DEF0_1357;
    m_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      e.data = 100'h5_A5A5_1234_5678_9ABC_DEF0_1357;
      e.last = (b == 3);
      e.fc   = 16'd0;
      sbq.push_back(e);
    end
    en = 1'b1;
    wait_acc(4, 20);
    chk_done("const", 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
